// File: rtl/uart_rx_oversample.sv
// UART receiver driven by an OVERSAMPLE x baud tick, with a 3-sample mid-bit majority vote.
// Optional parity bit after the data bits when UART_RX_PARITY_EN is defined.
module uart_rx_oversample #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sample_en,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_busy
);

    localparam int unsigned TW  = $clog2(OVERSAMPLE);
    localparam int unsigned BW  = $clog2(DATA_BITS + 1);
    localparam int unsigned MID = OVERSAMPLE / 2;

    localparam logic [TW-1:0] TickVoteLo = TW'(MID - 1);
    localparam logic [TW-1:0] TickVoteHi = TW'(MID + 1);
    localparam logic [TW-1:0] TickLast   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BitLast    = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StBreak
    } state_e;

    state_e               state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rxd_m;
    logic                 rxd_s;
    logic [2:0]           vote_sr;
    logic                 vote_now;
    logic                 vote_bit;
    logic                 parity_ok;

    function automatic logic maj3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_sr <= '0;
        end else if (sample_en && (tick_cnt >= TickVoteLo) && (tick_cnt <= TickVoteHi)) begin
            vote_sr <= {vote_sr[1:0], rxd_s};
        end
    end

    // At tick MID+1 the third sample is still on rxd_s, so fold it in directly.
    assign vote_now = maj3({vote_sr[1:0], rxd_s});
    assign vote_bit = maj3(vote_sr);

`ifdef UART_RX_PARITY_EN
    logic parity_bit;
    assign parity_ok = (parity_bit == ((^shift_reg) ^ (PARITY_ODD != 0)));
`else
    assign parity_ok     = 1'b1;
    assign rx_parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit    <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx_parity_err <= 1'b0;
`endif
            if (sample_en) begin
                tick_cnt <= (tick_cnt == TickLast) ? '0 : tick_cnt + 1'b1;
                case (state)
                    StIdle: begin
                        if (!rxd_s) begin
                            state    <= StStart;
                            tick_cnt <= '0;
                            rx_busy  <= 1'b1;
                        end
                    end
                    StStart: begin
                        if ((tick_cnt == TickVoteHi) && vote_now) begin
                            state   <= StIdle;
                            rx_busy <= 1'b0;
                        end else if (tick_cnt == TickLast) begin
                            state   <= StData;
                            bit_cnt <= '0;
                        end
                    end
                    StData: begin
                        if (tick_cnt == TickLast) begin
                            shift_reg <= {vote_bit, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BitLast) begin
`ifdef UART_RX_PARITY_EN
                                state <= StParity;
`else
                                state <= StStop;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    StParity: begin
                        if (tick_cnt == TickLast) begin
                            parity_bit <= vote_bit;
                            state      <= StStop;
                        end
                    end
`endif
                    // Deciding at MID+1 leaves half a bit of margin for an early next start edge.
                    StStop: begin
                        if (tick_cnt == TickVoteHi) begin
                            rx_data <= shift_reg;
                            if (!vote_now) begin
                                rx_frame_err <= 1'b1;
                                state        <= StBreak;
                            end else if (!parity_ok) begin
`ifdef UART_RX_PARITY_EN
                                rx_parity_err <= 1'b1;
`endif
                                state   <= StIdle;
                                rx_busy <= 1'b0;
                            end else begin
                                rx_valid <= 1'b1;
                                state    <= StIdle;
                                rx_busy  <= 1'b0;
                            end
                        end
                    end
                    StBreak: begin
                        if (rxd_s) begin
                            state   <= StIdle;
                            rx_busy <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= StIdle;
                        rx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: frame-level scoreboard checked every cycle,
// plus literal pins for reset, latency, glitch, break and mid-frame reset behaviour.
module tb_uart_rx_oversample;

    localparam int DB     = 8;
    localparam int OS     = 16;
    localparam int PODD   = 0;
    localparam int CPT    = 4;          // clk cycles per sample_en tick
    localparam int BITCLK = OS * CPT;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_PIN = 684;       // 4 + 4*(16*10 + 10)
`else
    localparam int LAT_PIN = 620;       // 4 + 4*(16*9 + 10)
`endif

    logic          clk;
    logic          rst_n;
    logic          sample_en;
    logic          rxd;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_frame_err;
    logic          rx_parity_err;
    logic          rx_busy;

    uart_rx_oversample #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .PARITY_ODD(PODD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sample_en    (sample_en),
        .rxd          (rxd),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_parity_err(rx_parity_err),
        .rx_busy      (rx_busy)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int fall_cyc   = 0;
    bit lat_armed  = 0;

    // Expected frame outcomes: kind 0 = valid, 1 = frame error, 2 = parity error.
    int            exp_kind[$];
    logic [DB-1:0] exp_data[$];
    logic [DB-1:0] model_data = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        sample_en = 1'b0;
        forever begin
            repeat (CPT - 1) begin
                @(posedge clk);
                #1 sample_en = 1'b0;
            end
            @(posedge clk);
            #1 sample_en = 1'b1;
        end
    end

    task automatic check(input string name, input int act, input int req);
        compared++;
        if (act != req) begin
            mismatched++;
            $display("FAIL %s: actual 0x%0h required 0x%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic logic good_par(input logic [DB-1:0] d);
        return (^d) ^ (PODD != 0);
    endfunction

    // Per-cycle compare of pulses and rx_data against the frame-level model.
    always @(negedge clk) begin
        int npulse;
        int kind_act;
        int k;
        if (!rst_n) begin
            model_data = '0;
        end else begin
            npulse = int'(rx_valid) + int'(rx_frame_err) + int'(rx_parity_err);
            if (npulse != 0) begin
                kind_act = rx_valid ? 0 : (rx_frame_err ? 1 : 2);
                check("pulse_exclusive", npulse, 1);
                if (exp_kind.size() == 0) begin
                    check("unexpected_pulse_kind", kind_act, -1);
                end else begin
                    k          = exp_kind.pop_front();
                    model_data = exp_data.pop_front();
                    check("pulse_kind", kind_act, k);
                    if (lat_armed) begin
                        check("latency_first_frame", cyc - fall_cyc, LAT_PIN);
                        lat_armed = 0;
                    end
                end
            end
        end
        check("rx_data", int'(rx_data), int'(model_data));
    end

    // Drives one frame starting on a tick edge; abort_bit >= 0 resets the DUT mid data bit.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic par,
                              input int abort_bit, input bit align, input bit arm_lat);
        if (align) begin
            do @(posedge clk); while (!sample_en);
            #1;
        end
        if (abort_bit < 0) begin
`ifdef UART_RX_PARITY_EN
            exp_kind.push_back(!stop ? 1 : ((par != good_par(d)) ? 2 : 0));
`else
            exp_kind.push_back(!stop ? 1 : 0);
`endif
            exp_data.push_back(d);
        end
        if (arm_lat) begin
            fall_cyc  = cyc;
            lat_armed = 1;
        end
        rxd = 1'b0;
        repeat (BITCLK) @(posedge clk);
        #1;
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            if (i == abort_bit) begin
                repeat (BITCLK / 2) @(posedge clk);
                #1;
                check("busy_before_reset", rx_busy, 1);
                rst_n = 1'b0;
                #1;
                check("reset_busy", rx_busy, 0);
                check("reset_valid", rx_valid, 0);
                check("reset_data", int'(rx_data), 0);
                rxd = 1'b1;
                repeat (10) @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            repeat (BITCLK) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        rxd = par;
        repeat (BITCLK) @(posedge clk);
        #1;
`else
        if (par) rxd = rxd;
`endif
        rxd = stop;
        repeat (BITCLK) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data", int'(rx_data), 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_frame_err", rx_frame_err, 0);
        check("reset_rx_parity_err", rx_parity_err, 0);
        check("reset_rx_busy", rx_busy, 0);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;

        // Good frame with latency pin.
        send_frame(8'h55, 1'b1, good_par(8'h55), -1, 1'b1, 1'b1);
        check("drain_0x55", exp_kind.size(), 0);
        check("data_0x55", int'(rx_data), 8'h55);
        check("busy_after_0x55", rx_busy, 0);
        repeat (BITCLK) @(posedge clk);
        #1;

        // Back-to-back frames.
        send_frame(8'hA3, 1'b1, good_par(8'hA3), -1, 1'b1, 1'b0);
        check("data_0xA3", int'(rx_data), 8'hA3);
        send_frame(8'h0F, 1'b1, good_par(8'h0F), -1, 1'b0, 1'b0);
        check("drain_b2b", exp_kind.size(), 0);
        check("data_0x0F", int'(rx_data), 8'h0F);
        check("busy_after_b2b", rx_busy, 0);
        repeat (BITCLK) @(posedge clk);
        #1;

        // Start glitch: low for 5 ticks only.
        do @(posedge clk); while (!sample_en);
        #1 rxd = 1'b0;
        repeat (3 * CPT) @(posedge clk);
        #1;
        check("glitch_busy_during", rx_busy, 1);
        repeat (2 * CPT) @(posedge clk);
        #1 rxd = 1'b1;
        repeat (12 * CPT) @(posedge clk);
        #1;
        check("glitch_busy_after", rx_busy, 0);
        repeat (BITCLK) @(posedge clk);
        #1;
        send_frame(8'h3C, 1'b1, good_par(8'h3C), -1, 1'b1, 1'b0);
        check("drain_0x3C", exp_kind.size(), 0);
        check("data_0x3C", int'(rx_data), 8'h3C);

        // Frame error followed by a 40-bit break.
        send_frame(8'h81, 1'b0, good_par(8'h81), -1, 1'b1, 1'b0);
        check("drain_0x81", exp_kind.size(), 0);
        check("data_0x81", int'(rx_data), 8'h81);
        repeat (20 * BITCLK) @(posedge clk);
        #1;
        check("break_busy_mid", rx_busy, 1);
        repeat (19 * BITCLK) @(posedge clk);
        #1;
        check("break_busy_end", rx_busy, 1);
        rxd = 1'b1;
        repeat (2 * BITCLK) @(posedge clk);
        #1;
        check("break_busy_released", rx_busy, 0);
        send_frame(8'h12, 1'b1, good_par(8'h12), -1, 1'b1, 1'b0);
        check("drain_0x12", exp_kind.size(), 0);
        check("data_0x12", int'(rx_data), 8'h12);

        // Reset during data bit 4, then a clean frame.
        send_frame(8'hF0, 1'b1, good_par(8'hF0), 4, 1'b1, 1'b0);
        repeat (2 * BITCLK) @(posedge clk);
        #1;
        check("post_reset_busy", rx_busy, 0);
        send_frame(8'h99, 1'b1, good_par(8'h99), -1, 1'b1, 1'b0);
        check("drain_0x99", exp_kind.size(), 0);
        check("data_0x99", int'(rx_data), 8'h99);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, -1, 1'b1, 1'b0);
        check("drain_par_good", exp_kind.size(), 0);
        check("data_par_good", int'(rx_data), 8'h07);
        send_frame(8'h07, 1'b1, 1'b0, -1, 1'b1, 1'b0);
        check("drain_par_bad", exp_kind.size(), 0);
        check("data_par_bad", int'(rx_data), 8'h07);
`endif

        repeat (BITCLK) @(posedge clk);
        #1;
        check("final_queue_empty", exp_kind.size(), 0);
        check("final_busy", rx_busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
